// File: rtl/sync_manager_mc_if.sv
// rtl/sync_manager_mc_if.sv - sample-side handshake and write-address bus of sync_manager_mc
// Signals:
//   S_valid   per-channel sample-present strobe (sample pipeline -> manager)
//   S_ready   per-channel grant, one-hot or zero (manager -> sample pipeline)
//   M_valid   write address valid (manager -> RAM writer)
//   M_address byte address of the granted sample
//   M_channel index of the granted channel
//   M_last    final sample of the whole window
// Modports: slave = manager side, master = sample pipeline / RAM writer side.
interface sync_manager_mc_if #(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int CHANNEL_COUNT = 4
);
  logic [CHANNEL_COUNT-1:0] S_valid;
  logic [CHANNEL_COUNT-1:0] S_ready;
  logic                     M_valid;
  logic [MM_ADDR_WIDTH-1:0] M_address;
  logic [2:0]               M_channel;
  logic                     M_last;

  modport slave (
    input  S_valid,
    output S_ready,
    output M_valid,
    output M_address,
    output M_channel,
    output M_last
  );

  modport master (
    output S_valid,
    input  S_ready,
    input  M_valid,
    input  M_address,
    input  M_channel,
    input  M_last
  );
endinterface

// File: rtl/sync_manager_mc.sv
// rtl/sync_manager_mc.sv - multi-channel capture window manager with round-robin address generation
// Ports:
//   SYS_aclk, SYS_areset  clock, synchronous active-high reset
//   SM_request            level request; a rising edge in IDLE arms a window
//   SM_log_length         log2 samples per channel (clamped to MAX_LOG_LENGTH)
//   SM_address            buffer base byte address (low sample bits ignored)
//   bus                   sample handshake + registered write-address output
//   SM_busy, SM_done      window armed/in progress, one-cycle completion pulse
//   SM_overflow           sticky: request edge seen while busy
//   SM_bank               (SM_PINGPONG_EN only) bank of the last completed window
// Build option: define SM_PINGPONG_EN for two alternating buffers.
module sync_manager_mc #(
  parameter int MM_ADDR_WIDTH    = 32,
  parameter int CHANNEL_COUNT    = 4,
  parameter int SAMPLE_BYTES_LOG = 2,
  parameter int MAX_LOG_LENGTH   = 16
) (
  input  logic                     SYS_aclk,
  input  logic                     SYS_areset,
  input  logic                     SM_request,
  input  logic [4:0]               SM_log_length,
  input  logic [MM_ADDR_WIDTH-1:0] SM_address,
  sync_manager_mc_if.slave         bus,
  output logic                     SM_busy,
  output logic                     SM_done,
`ifdef SM_PINGPONG_EN
  output logic                     SM_bank,
`endif
  output logic                     SM_overflow
);

  localparam int CNT_W = MAX_LOG_LENGTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic                     req_q;
  logic                     req_edge;
  logic                     accept;
  logic [4:0]               l_in;
  logic [4:0]               l_q;
  logic [MM_ADDR_WIDTH-1:0] base_in;
  logic [MM_ADDR_WIDTH-1:0] base_q;
  logic [CNT_W-1:0]         count [CHANNEL_COUNT];
  logic [CNT_W-1:0]         target;
  logic [CNT_W-1:0]         count_sel;
  logic [CHANNEL_COUNT-1:0] full;
  logic [CHANNEL_COUNT-1:0] near_full;
  logic [CHANNEL_COUNT-1:0] eligible;
  logic [CHANNEL_COUNT-1:0] grant;
  logic [7:0]               eligible_pad;
  logic [3:0]               cand;
  logic [2:0]               rr_ptr;
  logic [2:0]               grant_idx;
  logic                     grant_valid;
  logic                     last_grant;
  logic                     all_full;
  logic                     overflow_q;

  logic                     m_valid_q;
  logic [MM_ADDR_WIDTH-1:0] m_address_q;
  logic [2:0]               m_channel_q;
  logic                     m_last_q;

  assign req_edge = SM_request & ~req_q;
  assign accept   = req_edge && (state == ST_IDLE);
  assign l_in     = (SM_log_length > 5'(MAX_LOG_LENGTH)) ? 5'(MAX_LOG_LENGTH) : SM_log_length;
  assign target   = CNT_W'(1) << l_q;

`ifdef SM_PINGPONG_EN
  logic bank_nxt;   // bank the next accepted window will use
  logic win_bank;   // bank of the window currently armed

  // The second bank sits directly above the full set of channel regions.
  assign base_in = (SM_address & ~((MM_ADDR_WIDTH'(1) << SAMPLE_BYTES_LOG) - MM_ADDR_WIDTH'(1)))
                 + (bank_nxt ? (MM_ADDR_WIDTH'(CHANNEL_COUNT) << (l_in + SAMPLE_BYTES_LOG))
                             : '0);

  always_ff @(posedge SYS_aclk) begin
    if (SYS_areset) begin
      bank_nxt <= 1'b0;
      win_bank <= 1'b0;
      SM_bank  <= 1'b0;
    end else begin
      if (accept) begin
        win_bank <= bank_nxt;
        bank_nxt <= ~bank_nxt;
      end
      // Publish the bank as the window enters DONE so it is valid alongside SM_done.
      if (state == ST_CAPTURE && all_full) begin
        SM_bank <= win_bank;
      end
    end
  end
`else
  assign base_in = SM_address & ~((MM_ADDR_WIDTH'(1) << SAMPLE_BYTES_LOG) - MM_ADDR_WIDTH'(1));
`endif

  always_comb begin
    full      = '0;
    near_full = '0;
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      full[c]      = (count[c] == target);
      near_full[c] = (count[c] == target - CNT_W'(1));
    end
  end

  assign all_full = &full;
  assign eligible = (state == ST_CAPTURE) ? (bus.S_valid & ~full) : '0;

  // Round-robin: first eligible channel at or after rr_ptr, wrapping.
  always_comb begin
    eligible_pad                    = '0;
    eligible_pad[CHANNEL_COUNT-1:0] = eligible;
    cand                            = '0;
    grant_valid                     = 1'b0;
    grant_idx                       = '0;
    for (int k = 0; k < CHANNEL_COUNT; k++) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= 4'(CHANNEL_COUNT)) begin
        cand = cand - 4'(CHANNEL_COUNT);
      end
      if (!grant_valid && eligible_pad[cand[2:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[2:0];
      end
    end
  end

  always_comb begin
    grant     = '0;
    count_sel = '0;
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      if (grant_valid && grant_idx == 3'(c)) begin
        grant[c]  = 1'b1;
        count_sel = count[c];
      end
    end
  end

  // Window ends on the grant after which every channel is full.
  assign last_grant  = grant_valid & (&(full | (grant & near_full)));
  assign bus.S_ready = grant;

  always_comb begin
    state_nxt = state;
    SM_busy   = 1'b0;
    SM_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_edge) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        SM_busy = 1'b1;
        if (all_full) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        SM_busy   = 1'b1;
        SM_done   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYS_aclk) begin
    if (SYS_areset) begin
      state       <= ST_IDLE;
      req_q       <= 1'b0;
      l_q         <= '0;
      base_q      <= '0;
      rr_ptr      <= '0;
      overflow_q  <= 1'b0;
      m_valid_q   <= 1'b0;
      m_address_q <= '0;
      m_channel_q <= '0;
      m_last_q    <= 1'b0;
      for (int c = 0; c < CHANNEL_COUNT; c++) count[c] <= '0;
    end else begin
      state <= state_nxt;
      req_q <= SM_request;

      if (accept) begin
        l_q        <= l_in;
        base_q     <= base_in;
        overflow_q <= 1'b0;
        for (int c = 0; c < CHANNEL_COUNT; c++) count[c] <= '0;
      end else if (req_edge) begin
        overflow_q <= 1'b1;
      end

      m_valid_q <= grant_valid;
      m_last_q  <= last_grant;
      if (grant_valid) begin
        m_address_q <= base_q
                     + (MM_ADDR_WIDTH'(grant_idx) << (l_q + SAMPLE_BYTES_LOG))
                     + (MM_ADDR_WIDTH'(count_sel) << SAMPLE_BYTES_LOG);
        m_channel_q <= grant_idx;
        rr_ptr      <= (grant_idx == 3'(CHANNEL_COUNT - 1)) ? 3'd0 : grant_idx + 3'd1;
        for (int c = 0; c < CHANNEL_COUNT; c++) begin
          if (grant[c]) count[c] <= count[c] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.M_valid   = m_valid_q;
  assign bus.M_address = m_address_q;
  assign bus.M_channel = m_channel_q;
  assign bus.M_last    = m_last_q;
  assign SM_overflow   = overflow_q;

endmodule

// File: tb/tb_sync_manager_mc.sv
// tb/tb_sync_manager_mc.sv - scoreboard bench for sync_manager_mc
module tb_sync_manager_mc;
  localparam int AW = 32;
  localparam int CC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          SM_request = 1'b0;
  logic [4:0]    SM_log_length = '0;
  logic [AW-1:0] SM_address = '0;
  logic          SM_busy;
  logic          SM_done;
  logic          SM_overflow;
`ifdef SM_PINGPONG_EN
  logic          SM_bank;
`endif

  sync_manager_mc_if #(.MM_ADDR_WIDTH(AW), .CHANNEL_COUNT(CC)) bus();

  sync_manager_mc #(
    .MM_ADDR_WIDTH(AW), .CHANNEL_COUNT(CC), .SAMPLE_BYTES_LOG(2), .MAX_LOG_LENGTH(16)
  ) dut (
    .SYS_aclk     (clk),
    .SYS_areset   (rst),
    .SM_request   (SM_request),
    .SM_log_length(SM_log_length),
    .SM_address   (SM_address),
    .bus          (bus),
    .SM_busy      (SM_busy),
    .SM_done      (SM_done),
`ifdef SM_PINGPONG_EN
    .SM_bank      (SM_bank),
`endif
    .SM_overflow  (SM_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    ch;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   done_count = 0;
  logic last_prev = 1'b0;
  logic win_bank = 1'b0;
  logic bank_next = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bench-side bank tracking: each accepted request uses the next bank and flips it.
  task automatic accept_window();
    win_bank  = bank_next;
    bank_next = ~bank_next;
  endtask

  task automatic push(input int ch, input int idx, input int l, input logic [AW-1:0] base,
                      input logic last);
    exp_t e;
    logic [AW-1:0] a;
    a = base & 32'hFFFF_FFFC;
`ifdef SM_PINGPONG_EN
    if (win_bank) a = a + (32'(CC) << (l + 2));
`endif
    a = a + (32'(ch) << (l + 2)) + (32'(idx) << 2);
    e.addr = a;
    e.ch   = 3'(ch);
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic req_pulse();
    @(posedge clk); #1 SM_request = 1'b1;
    @(posedge clk); #1 SM_request = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    bit seen;
    start = done_count;
    seen  = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      if (done_count > start) seen = 1'b1;
    end
    #1;
    if (!seen) check_eq({tag, "_timeout"}, 64'(done_count - start), 64'd1);
  endtask

  // Monitor: scoreboard pop on each write address, grant shape and done timing.
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("s_ready_onehot0", 64'($onehot0(bus.S_ready)), 64'd1);
      if (bus.M_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_grant_valid", 64'(bus.M_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("m_address", 64'(bus.M_address), 64'(e.addr));
          check_eq("m_channel", 64'(bus.M_channel), 64'(e.ch));
          check_eq("m_last", 64'(bus.M_last), 64'(e.last));
        end
      end
      if (SM_done) begin
        done_count <= done_count + 1;
        check_eq("done_after_last", 64'(last_prev), 64'd1);
        check_eq("busy_during_done", 64'(SM_busy), 64'd1);
      end
      if (last_prev) check_eq("done_pulse", 64'(SM_done), 64'd1);
      last_prev <= bus.M_valid & bus.M_last;
    end else begin
      last_prev <= 1'b0;
    end
  end

  initial begin
    int dc;
    bus.S_valid = '0;

    // Reset with request high and every channel valid.
    rst = 1'b1;
    SM_request = 1'b1;
    bus.S_valid = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("reset_outputs",
               {56'd0, bus.M_valid, bus.M_last, SM_busy, SM_done, SM_overflow, 3'd0}, 64'd0);
      check_eq("reset_s_ready", 64'(bus.S_ready), 64'd0);
      if (i == 2) SM_request = 1'b0;
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("idle_after_reset_busy", 64'(SM_busy), 64'd0);
      check_eq("idle_after_reset_ready", 64'(bus.S_ready), 64'd0);
    end

    // Full window, L=3, all channels valid: strict ch0..3 rotation.
    SM_address    = 32'h1000;
    SM_log_length = 5'd3;
    accept_window();
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < CC; c++)
        push(c, i, 3, 32'h1000, (i == 7 && c == CC - 1));
    req_pulse();
    check_eq("busy_after_req", 64'(SM_busy), 64'd1);
    wait_done("win_l3", 80);
    check_eq("win_l3_sb_empty", 64'(exp_q.size()), 64'd0);
    check_eq("idle_after_done", 64'(SM_busy), 64'd0);

    // Unaligned base, L=2, only ch2 valid; then overflow edge mid-capture.
    bus.S_valid   = '0;
    SM_address    = 32'h1003;
    SM_log_length = 5'd2;
    accept_window();
    for (int i = 0; i < 4; i++) push(2, i, 2, 32'h1003, 1'b0);
    bus.S_valid = 4'b0100;
    req_pulse();
    repeat (10) @(posedge clk);
    #1;
    check_eq("ch2_only_busy", 64'(SM_busy), 64'd1);
    check_eq("ch2_full_no_ready", 64'(bus.S_ready), 64'd0);
    check_eq("ch2_only_sb_empty", 64'(exp_q.size()), 64'd0);
    check_eq("ch2_only_no_done", 64'(done_count), 64'd1);
    req_pulse();
    check_eq("overflow_set", 64'(SM_overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      push(3, i, 2, 32'h1003, 1'b0);
      push(0, i, 2, 32'h1003, 1'b0);
      push(1, i, 2, 32'h1003, (i == 3));
    end
    bus.S_valid = '1;
    wait_done("win_ch2", 60);
    check_eq("win_ch2_sb_empty", 64'(exp_q.size()), 64'd0);
    check_eq("overflow_sticky", 64'(SM_overflow), 64'd1);

    // Clamped length: L=20 -> 16, ch1 region at base + 0x40000; then reset mid-capture.
    bus.S_valid   = '0;
    SM_address    = 32'h2000;
    SM_log_length = 5'd20;
    accept_window();
    for (int i = 0; i < 3; i++) push(1, i, 16, 32'h2000, 1'b0);
    req_pulse();
    check_eq("overflow_cleared", 64'(SM_overflow), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 bus.S_valid = 4'b0010;
      @(posedge clk); #1 bus.S_valid = 4'b0000;
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq("clamp_sb_empty", 64'(exp_q.size()), 64'd0);
    check_eq("clamp_busy", 64'(SM_busy), 64'd1);
    dc = done_count;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_busy", 64'(SM_busy), 64'd0);
    check_eq("abort_m_valid", 64'(bus.M_valid), 64'd0);
    rst = 1'b0;
    bank_next = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("abort_no_done", 64'(done_count), 64'(dc));
    check_eq("abort_stays_idle", 64'(SM_busy), 64'd0);

`ifdef SM_PINGPONG_EN
    // Two windows at base 0: second lands in bank 1 (ch0 at 0x80).
    bus.S_valid   = '1;
    SM_address    = 32'h0;
    SM_log_length = 5'd3;
    for (int w = 0; w < 2; w++) begin
      accept_window();
      for (int i = 0; i < 8; i++)
        for (int c = 0; c < CC; c++)
          push(c, i, 3, 32'h0, (i == 7 && c == CC - 1));
      req_pulse();
      wait_done("pingpong", 80);
      check_eq("pingpong_bank", 64'(SM_bank), 64'(w));
    end
    check_eq("pingpong_sb_empty", 64'(exp_q.size()), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
